// File: rtl/sshooter_audio_pkg.sv
// Shared types and constants for the sshooter audio mixer.
// Used by sshooter_audio_mix and sshooter_mix_sat.
package sshooter_audio_pkg;

   localparam int         ACC_W     = 26;
   localparam int         LEVEL_W   = 5;
   localparam logic [4:0] LEVEL_MAX = 5'd16;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      SAT,
      OUT
   } mix_state_t;

endpackage

// File: rtl/sshooter_mix_sat.sv
// Signed 26-to-16 saturator; clamps when SSHOOTER_MIX_CLIP_EN
// is defined, otherwise keeps the low 16 bits (wraps).
module sshooter_mix_sat
   import sshooter_audio_pkg::*;
(
   input  logic [ACC_W-1:0] din,
   output logic [15:0]      dout
);

`ifdef SSHOOTER_MIX_CLIP_EN
   localparam logic signed [ACC_W-1:0] MAXV = 26'sd32767;
   localparam logic signed [ACC_W-1:0] MINV = -26'sd32768;

   // clamp the accumulator into the signed 16-bit range
   always_comb begin
      dout = din[15:0];
      if ($signed(din) > MAXV)
         dout = 16'h7fff;
      else if ($signed(din) < MINV)
         dout = 16'h8000;
   end
`else
   logic hi_unused;

   assign hi_unused = ^din[ACC_W-1:16];

   // two's-complement wrap: keep the low half only
   always_comb begin
      dout = din[15:0];
   end
`endif

endmodule

// File: rtl/sshooter_audio_mix.sv
// FM + 3xSSG time-multiplexed mixer with one shared MAC,
// saturation (SSHOOTER_MIX_CLIP_EN) and a soft-mute ramp.
module sshooter_audio_mix
   import sshooter_audio_pkg::*;
#(
   parameter logic [7:0] GAIN_FM  = 8'd2,
   parameter logic [7:0] GAIN_SSG = 8'd42,
   parameter int         SHIFT    = 0
)(
   input  logic        clk_49m,
   input  logic        reset,
   input  logic        sample_cen,
   input  logic [15:0] fm_in,
   input  logic [15:0] ssg_a_in,
   input  logic [15:0] ssg_b_in,
   input  logic [15:0] ssg_c_in,
   input  logic        mute,
   output logic [15:0] sound,
   output logic        out_valid,
   output logic        overrun
);

   mix_state_t         state;
   mix_state_t         state_nx;
   logic [15:0]        hold [4];
   logic [1:0]         ch;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_shr;
   logic [15:0]        sat_d;
   logic [15:0]        sat_q;
   logic [LEVEL_W-1:0] level;
   logic [7:0]         gain_cur;
   logic [15:0]        x_cur;
   logic signed [24:0] mac_prod;
   logic signed [20:0] lvl_prod;
   logic               lvl_unused;

   assign x_cur    = hold[ch];
   assign gain_cur = (ch == 2'd0) ? GAIN_FM : GAIN_SSG;
   assign mac_prod = $signed({{9{x_cur[15]}}, x_cur})
                   * $signed({17'd0, gain_cur});
   assign acc_shr  = $signed(acc) >>> SHIFT;
   assign lvl_prod = $signed({{5{sat_q[15]}}, sat_q})
                   * $signed({16'd0, level});
   assign lvl_unused = ^{lvl_prod[20], lvl_prod[3:0]};

   sshooter_mix_sat u_sat (
      .din  (acc_shr),
      .dout (sat_d)
   );

   // state register
   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // sequence IDLE -> 4x MAC -> SAT -> OUT -> IDLE
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (sample_cen) state_nx = MAC;
         MAC:  if (ch == 2'd3) state_nx = SAT;
         SAT:  state_nx = OUT;
         OUT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // capture, accumulate, saturate, scale by level, flag overruns
   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++)
            hold[i] <= '0;
         ch        <= '0;
         acc       <= '0;
         sat_q     <= '0;
         sound     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         level     <= '0;
      end else begin
         out_valid <= 1'b0;
         if (sample_cen && state != IDLE)
            overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (sample_cen) begin
                  hold[0] <= fm_in;
                  hold[1] <= ssg_a_in;
                  hold[2] <= ssg_b_in;
                  hold[3] <= ssg_c_in;
                  acc     <= '0;
                  ch      <= '0;
               end
            end
            MAC: begin
               acc <= acc + {mac_prod[24], mac_prod};
               ch  <= ch + 2'd1;
            end
            SAT: begin
               sat_q <= sat_d;
            end
            OUT: begin
               sound     <= lvl_prod[19:4];
               out_valid <= 1'b1;
               if (mute && level != '0)
                  level <= level - 5'd1;
               else if (!mute && level < LEVEL_MAX)
                  level <= level + 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sshooter_audio_mix.sv
// Scoreboard bench for sshooter_audio_mix with a
// sample-level reference model of mix, clip/wrap and fade.
module tb_sshooter_audio_mix;

   logic        clk_49m = 1'b0;
   logic        reset = 1'b0;
   logic        sample_cen = 1'b0;
   logic        mute = 1'b0;
   logic [15:0] fm_in = '0;
   logic [15:0] ssg_a_in = '0;
   logic [15:0] ssg_b_in = '0;
   logic [15:0] ssg_c_in = '0;
   logic [15:0] sound;
   logic        out_valid;
   logic        overrun;

   typedef struct {
      int val;
      int due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   m_level = 0;
   int   last_acc = -100;
   int   m_ovr = 0;

   sshooter_audio_mix dut (
      .clk_49m    (clk_49m),
      .reset      (reset),
      .sample_cen (sample_cen),
      .fm_in      (fm_in),
      .ssg_a_in   (ssg_a_in),
      .ssg_b_in   (ssg_b_in),
      .ssg_c_in   (ssg_c_in),
      .mute       (mute),
      .sound      (sound),
      .out_valid  (out_valid),
      .overrun    (overrun)
   );

   always #10 clk_49m = ~clk_49m;

   always @(posedge clk_49m) cyc++;

   function automatic void check(string nm, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endfunction

   function automatic int ref_mix(int fm, int a, int b, int c);
      int s;
      s = fm * 2 + (a + b + c) * 42;
`ifdef SSHOOTER_MIX_CLIP_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`else
      s = ((s % 65536) + 65536) % 65536;
      if (s >= 32768) s = s - 65536;
`endif
      return s;
   endfunction

   function automatic int floor16(int p);
      return (p - (((p % 16) + 16) % 16)) / 16;
   endfunction

   function automatic int rnd16();
      logic [15:0] r;
      r = 16'($urandom);
      return int'($signed(r));
   endfunction

   task automatic strobe(int fm, int a, int b, int c,
                         int m, int gap);
      int   t;
      exp_t e;
      @(negedge clk_49m);
      fm_in      = 16'(fm);
      ssg_a_in   = 16'(a);
      ssg_b_in   = 16'(b);
      ssg_c_in   = 16'(c);
      mute       = m[0];
      sample_cen = 1'b1;
      t = cyc + 1;
      if (t - last_acc >= 7) begin
         last_acc = t;
         e.val = floor16(ref_mix(fm, a, b, c) * m_level);
         e.due = t + 6;
         sb.push_back(e);
         if (m != 0 && m_level > 0) m_level--;
         else if (m == 0 && m_level < 16) m_level++;
      end else begin
         m_ovr = 1;
      end
      @(negedge clk_49m);
      sample_cen = 1'b0;
      repeat (gap - 1) @(negedge clk_49m);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 300) begin
         @(negedge clk_49m);
         guard++;
      end
      if (sb.size() > 0)
         check("drain_pending", sb.size(), 0);
   endtask

   // monitor: pop and compare whenever the DUT presents a sample
   always @(negedge clk_49m) begin
      exp_t e;
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("sound", int'($signed(sound)), e.val);
            check("latency", cyc, e.due);
         end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
         check("missing_valid", cyc, sb[0].due);
         void'(sb.pop_front());
      end
   end

   initial begin
      repeat (3) @(negedge clk_49m);
      check("rst_sound", int'(sound), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_overrun", int'(overrun), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk_49m);

      for (int k = 0; k < 18; k++)
         strobe(1000, 0, 0, 0, 0, 128);
      strobe(0, 100, 100, 100, 0, 20);
      strobe(30000, 0, 0, 0, 0, 20);
      strobe(0, -1000, 0, 0, 0, 20);
      strobe(-30000, -30000, -30000, -30000, 0, 20);

      for (int k = 0; k < 17; k++)
         strobe(1000, 0, 0, 0, 1, 10);
      for (int k = 0; k < 16; k++)
         strobe(rnd16(), rnd16(), rnd16(), rnd16(), 0, 7);
      for (int k = 0; k < 40; k++)
         strobe(rnd16(), rnd16(), rnd16(), rnd16(),
                int'($urandom_range(0, 1)),
                int'($urandom_range(7, 20)));
      drain();

      check("overrun_clear", int'(overrun), m_ovr);
      strobe(500, 0, 0, 0, 0, 3);
      strobe(-7000, 1234, 0, 0, 0, 20);
      check("overrun_set", int'(overrun), m_ovr);
      strobe(800, 0, 0, 0, 0, 20);
      check("overrun_sticky", int'(overrun), m_ovr);
      drain();

      strobe(1000, 0, 0, 0, 0, 4);
      reset = 1'b0;
      void'(sb.pop_back());
      m_level = 0;
      m_ovr = 0;
      last_acc = -100;
      #1;
      check("abort_sound", int'(sound), 0);
      check("abort_overrun", int'(overrun), 0);
      check("abort_valid", int'(out_valid), 0);
      repeat (2) @(negedge clk_49m);
      reset = 1'b1;
      repeat (12) @(negedge clk_49m);
      strobe(1000, 0, 0, 0, 0, 10);
      strobe(1000, 0, 0, 0, 0, 10);
      drain();
      check("post_overrun", int'(overrun), m_ovr);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
